// File: rtl/msg_tx_scheduler.sv
// Keyboard message buffer with backspace, frozen and handed to the GPIO link via a data_ready/tx_done handshake.
// Latency: accepted key visible 1 cycle after its strobe; minimum send-to-EDIT round trip 4 cycles.
// Backpressure: keys arriving while busy or with a full buffer are discarded and flagged on dropped; each handshake phase is bounded by a watchdog.
module msg_tx_scheduler #(
    parameter int MSG_CHARS      = 16,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                           clock,
    input  logic                           RESETN,
    input  logic                           key_valid,
    input  logic [7:0]                     key_ascii,
    input  logic                           send_req,
    input  logic                           tx_done,
    output logic [8*MSG_CHARS-1:0]         message_out,
    output logic                           data_ready,
    output logic [$clog2(MSG_CHARS+1)-1:0] char_count,
    output logic                           busy,
    output logic                           dropped,
    output logic                           tx_ok,
    output logic                           tx_err
);

    localparam int CNT_W = $clog2(MSG_CHARS+1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_CHARS);
    // Abort on the edge where the watchdog would step onto TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]       KEY_DEL  = 8'd127;

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [WD_W-1:0]   wd_q;
    logic              wd_clr;
    logic              wd_inc;
    logic              do_append;
    logic              do_delete;
    logic              do_clear;
    logic              drop_nxt;
    logic              ok_nxt;
    logic              err_nxt;

    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_EDIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        do_append = 1'b0;
        do_delete = 1'b0;
        do_clear  = 1'b0;
        drop_nxt  = 1'b0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (send_req && (char_count != '0)) begin
                    state_nxt = ST_REQ;
                    wd_clr    = 1'b1;
                    drop_nxt  = key_valid;
                end else if (key_valid) begin
                    if (key_ascii == KEY_DEL) begin
                        do_delete = (char_count != '0);
                    end else if (char_count == CNT_FULL) begin
                        drop_nxt  = 1'b1;
                    end else begin
                        do_append = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                drop_nxt = key_valid;
                if (tx_done) begin
                    state_nxt = ST_RELEASE;
                    wd_clr    = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    // Buffer is kept so the user can retry the send.
                    state_nxt = ST_EDIT;
                    err_nxt   = 1'b1;
                    wd_inc    = 1'b1;
                end else begin
                    wd_inc    = 1'b1;
                end
            end
            ST_RELEASE: begin
                drop_nxt = key_valid;
                if (!tx_done) begin
                    state_nxt = ST_CLEAR;
                    ok_nxt    = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    // Transmitter already took the message, so clear anyway.
                    state_nxt = ST_CLEAR;
                    err_nxt   = 1'b1;
                    wd_inc    = 1'b1;
                end else begin
                    wd_inc    = 1'b1;
                end
            end
            ST_CLEAR: begin
                drop_nxt  = key_valid;
                do_clear  = 1'b1;
                state_nxt = ST_EDIT;
            end
            default: begin
                state_nxt = ST_EDIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            message_out <= '0;
            char_count  <= '0;
            wd_q        <= '0;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            dropped     <= 1'b0;
            tx_ok       <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            if (do_clear) begin
                message_out <= '0;
                char_count  <= '0;
            end else if (do_append) begin
                message_out[8*(MSG_CHARS-1-int'(char_count)) +: 8] <= key_ascii;
                char_count <= char_count + CNT_W'(1);
            end else if (do_delete) begin
                message_out[8*(MSG_CHARS-int'(char_count)) +: 8] <= 8'h00;
                char_count <= char_count - CNT_W'(1);
            end

            if (wd_clr) begin
                wd_q <= '0;
            end else if (wd_inc) begin
                wd_q <= wd_q + WD_W'(1);
            end

            data_ready <= (state_nxt == ST_REQ);
            busy       <= (state_nxt != ST_EDIT);
            dropped    <= drop_nxt;
            tx_ok      <= ok_nxt;
            tx_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Directed bench for msg_tx_scheduler: cycle table for typing/handshake/timeouts, plus fill, delete and reset sequences.
module tb_msg_tx_scheduler;

    localparam int MSG_CHARS = 16;
    localparam int TO        = 8;

    logic         clock = 1'b0;
    logic         RESETN = 1'b0;
    logic         key_valid = 1'b0;
    logic [7:0]   key_ascii = 8'h00;
    logic         send_req = 1'b0;
    logic         tx_done = 1'b0;
    logic [127:0] message_out;
    logic         data_ready;
    logic [4:0]   char_count;
    logic         busy;
    logic         dropped;
    logic         tx_ok;
    logic         tx_err;

    int n_cmp = 0;
    int n_bad = 0;

    msg_tx_scheduler #(.MSG_CHARS(MSG_CHARS), .TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .RESETN      (RESETN),
        .key_valid   (key_valid),
        .key_ascii   (key_ascii),
        .send_req    (send_req),
        .tx_done     (tx_done),
        .message_out (message_out),
        .data_ready  (data_ready),
        .char_count  (char_count),
        .busy        (busy),
        .dropped     (dropped),
        .tx_ok       (tx_ok),
        .tx_err      (tx_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         kv;
        logic [7:0]   ka;
        logic         sr;
        logic         td;
        logic [159:0] exp;
    } vec_t;

    vec_t vq[$];

    localparam logic [127:0] M0  = '0;
    localparam logic [127:0] H1  = {8'h68, 120'h0};
    localparam logic [127:0] HI  = {16'h6869, 112'h0};
    localparam logic [127:0] X1  = {8'h78, 120'h0};
    localparam logic [127:0] A1  = {8'h61, 120'h0};
    localparam logic [127:0] AB  = {16'h6162, 112'h0};
    localparam logic [127:0] ABC = {24'h616263, 104'h0};

    function automatic logic [159:0] mk(input logic [127:0] m, input logic [4:0] c,
                                        input logic d, input logic r, input logic b,
                                        input logic o, input logic e);
        return {22'b0, m, c, d, r, b, o, e};
    endfunction

    function automatic logic [159:0] obs();
        return {22'b0, message_out, char_count, dropped, data_ready, busy, tx_ok, tx_err};
    endfunction

    task automatic add(input logic kv, input logic [7:0] ka, input logic sr, input logic td,
                       input logic [127:0] m, input logic [4:0] c, input logic d,
                       input logic r, input logic b, input logic o, input logic e);
        vec_t v;
        v.kv = kv; v.ka = ka; v.sr = sr; v.td = td;
        v.exp = mk(m, c, d, r, b, o, e);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // "hi" then send; tx_done rises 3 cycles after data_ready, falls 2 later
        add(0, 8'h00, 0, 0, M0,  0, 0, 0, 0, 0, 0);
        add(1, 8'h68, 0, 0, H1,  1, 0, 0, 0, 0, 0);
        add(1, 8'h69, 0, 0, HI,  2, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, HI,  2, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, HI, 2, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, HI,  2, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, HI,  2, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, HI,  2, 0, 0, 1, 1, 0);
        add(0, 8'h00, 0, 0, M0,  0, 0, 0, 0, 0, 0);
        // empty buffer: delete and send ignored; send+key with count 0 takes the key
        add(1, 8'd127, 0, 0, M0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, M0,  0, 0, 0, 0, 0, 0);
        add(1, 8'h78, 1, 0, X1,  1, 0, 0, 0, 0, 0);
        add(1, 8'd127, 0, 0, M0, 0, 0, 0, 0, 0, 0);
        // count 3, send+key together, key during REQ, then REQ timeout
        add(1, 8'h61, 0, 0, A1,  1, 0, 0, 0, 0, 0);
        add(1, 8'h62, 0, 0, AB,  2, 0, 0, 0, 0, 0);
        add(1, 8'h63, 0, 0, ABC, 3, 0, 0, 0, 0, 0);
        add(1, 8'h7a, 1, 0, ABC, 3, 1, 1, 1, 0, 0);
        add(1, 8'h79, 0, 0, ABC, 3, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, ABC, 3, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, ABC, 3, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, ABC, 3, 0, 0, 0, 0, 0);
        // tx_done stuck high in RELEASE: timeout then clear
        add(0, 8'h00, 1, 0, ABC, 3, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, ABC, 3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 0, 1, ABC, 3, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, ABC, 3, 0, 0, 1, 0, 1);
        add(0, 8'h00, 0, 0, M0,  0, 0, 0, 0, 0, 0);

        #3;
        chk("reset_state", obs(), mk(M0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1;
        RESETN = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            key_valid = vq[i].kv;
            key_ascii = vq[i].ka;
            send_req  = vq[i].sr;
            tx_done   = vq[i].td;
            step();
            chk($sformatf("row%0d", i), obs(), vq[i].exp);
        end
        key_valid = 1'b0;
        send_req  = 1'b0;
        tx_done   = 1'b0;

        // 17 keys into a 16-char buffer: only the last is dropped
        for (int i = 0; i < 17; i++) begin
            key_valid = 1'b1;
            key_ascii = 8'(8'h61 + i);
            step();
            chk($sformatf("fill_drop%0d", i), {159'b0, dropped}, {159'b0, (i == 16)});
        end
        key_valid = 1'b0;
        step();
        chk("fill_state", obs(), mk("abcdefghijklmnop", 16, 0, 0, 0, 0, 0));
        key_valid = 1'b1;
        key_ascii = 8'd127;
        step();
        step();
        key_valid = 1'b0;
        chk("delete2", obs(), mk({"abcdefghijklmn", 16'h0}, 14, 0, 0, 0, 0, 0));

        // reset in the middle of REQ
        send_req = 1'b1;
        step();
        send_req = 1'b0;
        chk("req_before_reset", obs(), mk({"abcdefghijklmn", 16'h0}, 14, 0, 1, 1, 0, 0));
        #2;
        RESETN = 1'b0;
        #1;
        chk("reset_async", obs(), mk(M0, 0, 0, 0, 0, 0, 0));
        tx_done = 1'b1;
        step();
        step();
        chk("reset_hold", obs(), mk(M0, 0, 0, 0, 0, 0, 0));
        tx_done = 1'b0;
        RESETN  = 1'b1;
        key_valid = 1'b1;
        key_ascii = 8'h6b;
        step();
        key_valid = 1'b0;
        chk("type_after_reset", obs(), mk({8'h6b, 120'h0}, 1, 0, 0, 0, 0, 0));
        step();
        chk("idle_after_reset", obs(), mk({8'h6b, 120'h0}, 1, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_tx_scheduler.md
# msg_tx_scheduler

Sequences the outgoing keyboard message path. It collects ASCII characters from the PS2 decode into a fixed-length message buffer, with backspace support. On a send request it presents the frozen buffer to the GPIO link transmitter using a data_ready/done four-phase handshake, with a timeout watchdog. It sits between the PS2 ASCII decode and `gpio_protocol`, and replaces the ad-hoc edge-triggered buffer and `data_ready` logic at the top level.

## Interface
Parameters:
- `MSG_CHARS`, 16: buffer depth in characters; message width is 8*MSG_CHARS.
- `TIMEOUT_CYCLES`, 200_000_000: maximum cycles spent in each handshake phase before abort. Minimum 2.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `RESETN`  in  1  reset, asynchronous and active-low.
- `key_valid`  in  1  one-cycle strobe; `key_ascii` is valid while it is high. Already synchronous to `clock`.
- `key_ascii`  in  8  ASCII code. 8'd127 = delete; any other value = a character to append.
- `send_req`  in  1  one-cycle strobe requesting transmission.
- `tx_done`  in  1  level input from the transmitter; high = message consumed. Synchronised externally.
- `message_out`  out  8*MSG_CHARS  character 0 at the MSB byte [8*MSG_CHARS-1 -: 8]; unused slots are 8'h00.
- `data_ready`  out  1  request to the transmitter.
- `char_count`  out  $clog2(MSG_CHARS+1)  number of valid characters.
- `busy`  out  1  high in any state other than EDIT.
- `dropped`  out  1  one-cycle pulse when a key strobe is discarded.
- `tx_ok`  out  1  one-cycle pulse when a transmission completes.
- `tx_err`  out  1  one-cycle pulse when the watchdog aborts a transmission.

## Operation
States: EDIT, REQ, RELEASE, CLEAR.

Reset (asynchronous, on RESETN low): state = EDIT, all buffer bytes = 8'h00, `char_count` = 0, watchdog = 0, and every output = 0.

EDIT:
- Non-delete key with `char_count` < MSG_CHARS: write to slot `char_count`, then increment the count.
- Non-delete key with `char_count` == MSG_CHARS: the key is discarded and `dropped` pulses.
- Delete with `char_count` > 0: decrement the count and clear that slot to 8'h00.
- Delete with `char_count` == 0: no change; `dropped` does not pulse.
- `send_req` with `char_count` > 0: go to REQ and clear the watchdog.
- `send_req` with `char_count` == 0: ignored.
- `send_req` and `key_valid` in the same cycle: send wins, the key is discarded, and `dropped` pulses. If the count is 0, the send is ignored and the key is processed normally.

REQ:
- `data_ready` = 1. The buffer is frozen.
- When `tx_done` is seen high, go to RELEASE and clear the watchdog.
- If the watchdog reaches TIMEOUT_CYCLES-1 first, pulse `tx_err` and return to EDIT with the buffer intact.

RELEASE:
- `data_ready` = 0.
- When `tx_done` is seen low, pulse `tx_ok` and go to CLEAR.
- On timeout, pulse `tx_err` and go to CLEAR (the message was already consumed).

CLEAR:
- One cycle. Zero all bytes and set `char_count` to 0, then go to EDIT.

Keys and `send_req` received in REQ, RELEASE or CLEAR:
- A key strobe is discarded and `dropped` pulses.
- `send_req` is ignored silently.

Watchdog:
- Counter of width $clog2(TIMEOUT_CYCLES).
- Increments every cycle in REQ and RELEASE.
- Saturates when the abort fires.

## Timing
- All outputs are registered. An accepted key is visible on `message_out` and `char_count` on the edge after its strobe.
- `send_req` at edge N gives `data_ready` high and `busy` high from edge N+1.
- `tx_done` sampled high at edge M gives `data_ready` low from M+1.
- `tx_done` sampled low at edge K:
  - `tx_ok` is high for cycle K+1.
  - The buffer is cleared and state = EDIT from edge K+2.
  - Minimum round trip with an immediate transmitter: 4 cycles from `send_req` to EDIT.
- `tx_done` already high on entering REQ is accepted on the first REQ cycle. `data_ready` is still high for at least one cycle.
- A timeout in REQ with the watchdog started at edge N fires `tx_err` in cycle N+TIMEOUT_CYCLES, and `data_ready` drops on the same edge.
- `message_out` is stable from the REQ entry edge through the RELEASE exit edge.
- RESETN asserted mid-handshake: `data_ready` drops immediately (asynchronously) and no `tx_ok` or `tx_err` pulse is emitted.

## Test plan
- Type "hi" (0x68, 0x69) then `send_req`, with `tx_done` rising 3 cycles after `data_ready` and falling 2 cycles later:
  - `message_out` = {0x68, 0x69, 14×0x00} and `char_count` = 2.
  - `data_ready` is high for exactly 4 cycles.
  - One `tx_ok` pulse, then `char_count` = 0.
- 17 keys 'a'..'q': bytes 'a'..'p' are stored, `char_count` = 16, and `dropped` pulses once (on 'q'). Then delete ×2: `char_count` = 14 and slots 14–15 = 0x00.
- Delete on an empty buffer, and `send_req` on an empty buffer: no state change, no `dropped`, `data_ready` stays 0.
- `send_req` and a key in the same cycle with count 3:
  - REQ is entered with count 3.
  - `dropped` pulses.
  - A key during REQ gives another `dropped` pulse and the buffer is unchanged.
- TIMEOUT_CYCLES = 8 with `tx_done` held 0:
  - `tx_err` pulses 8 cycles after REQ entry.
  - State returns to EDIT and the buffer is preserved.
  - Repeat with `tx_done` stuck high in RELEASE: `tx_err` pulses and the buffer is cleared.
- RESETN pulsed low mid-REQ: `data_ready`, `message_out` and `char_count` are 0 immediately. After release, normal typing resumes.
